// File: rtl/ex_unit.sv
// ex_unit -- registered execution unit sitting between the reservation
// station and the CDB. Executes RV32I ALU/branch/jump ops in one cycle,
// RV32M multiplies in MUL_CYCLES cycles and divides/remainders in XLEN+1
// cycles. One operation in flight; the result is held until the CDB arbiter
// grants it. A ROB rollback (flush) discards whatever is in flight.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global enable; low freezes all state
//   flush           ROB rollback, discards the in-flight op and result
//   in_flag         RS issues an op this cycle
//   in_ready        unit can accept an op this cycle
//   in_code         6-bit op code (OP_* below)
//   in_v1, in_v2    register operands
//   in_a            immediate
//   in_pc           instruction PC
//   in_rob_id       destination ROB entry
//   out_valid       result available to the CDB
//   cdb_grant       arbiter consumes the result this cycle
//   out_rob_id      ROB entry of the result
//   out_val         writeback value
//   out_rel_pc      resolved next PC
module ex_unit #(
  parameter int XLEN       = 32,
  parameter int ROBW       = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            in_flag,
  output logic            in_ready,
  input  logic [5:0]      in_code,
  input  logic [XLEN-1:0] in_v1,
  input  logic [XLEN-1:0] in_v2,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ROBW-1:0] in_rob_id,
  output logic            out_valid,
  input  logic            cdb_grant,
  output logic [ROBW-1:0] out_rob_id,
  output logic [XLEN-1:0] out_val,
  output logic [XLEN-1:0] out_rel_pc
);

  // Op code encodings shared with the decoder.
  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_SLL    = 6'd2;
  localparam logic [5:0] OP_SLT    = 6'd3;
  localparam logic [5:0] OP_SLTU   = 6'd4;
  localparam logic [5:0] OP_XOR    = 6'd5;
  localparam logic [5:0] OP_SRL    = 6'd6;
  localparam logic [5:0] OP_SRA    = 6'd7;
  localparam logic [5:0] OP_OR     = 6'd8;
  localparam logic [5:0] OP_AND    = 6'd9;
  localparam logic [5:0] OP_ADDI   = 6'd10;
  localparam logic [5:0] OP_SLTI   = 6'd11;
  localparam logic [5:0] OP_SLTIU  = 6'd12;
  localparam logic [5:0] OP_XORI   = 6'd13;
  localparam logic [5:0] OP_ORI    = 6'd14;
  localparam logic [5:0] OP_ANDI   = 6'd15;
  localparam logic [5:0] OP_SLLI   = 6'd16;
  localparam logic [5:0] OP_SRLI   = 6'd17;
  localparam logic [5:0] OP_SRAI   = 6'd18;
  localparam logic [5:0] OP_LUI    = 6'd19;
  localparam logic [5:0] OP_AUIPC  = 6'd20;
  localparam logic [5:0] OP_JAL    = 6'd21;
  localparam logic [5:0] OP_JALR   = 6'd22;
  localparam logic [5:0] OP_BEQ    = 6'd23;
  localparam logic [5:0] OP_BNE    = 6'd24;
  localparam logic [5:0] OP_BLT    = 6'd25;
  localparam logic [5:0] OP_BGE    = 6'd26;
  localparam logic [5:0] OP_BLTU   = 6'd27;
  localparam logic [5:0] OP_BGEU   = 6'd28;
  localparam logic [5:0] OP_MUL    = 6'd32;
  localparam logic [5:0] OP_MULH   = 6'd33;
  localparam logic [5:0] OP_MULHSU = 6'd34;
  localparam logic [5:0] OP_MULHU  = 6'd35;
  localparam logic [5:0] OP_DIV    = 6'd36;
  localparam logic [5:0] OP_DIVU   = 6'd37;
  localparam logic [5:0] OP_REM    = 6'd38;
  localparam logic [5:0] OP_REMU   = 6'd39;

  localparam int CNT_W      = $clog2(XLEN + 1);
  // A single-cycle multiplier finishes on the accept edge like a simple op.
  localparam bit MUL_DIRECT = (MUL_CYCLES == 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [5:0]        code_r;
  logic [XLEN-1:0]   v1_r;
  logic [XLEN-1:0]   v2_r;
  logic [XLEN-1:0]   quot_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   dvs_r;

  logic              accept;
  logic              in_is_mul;
  logic              in_is_div;
  logic              in_signed_div;

  // Magnitude of a two's complement value when it is treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x,
                                          input logic            sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  // Sign fix-up and RISC-V corner cases applied to the unsigned quotient
  // and remainder. MIN / -1 falls out naturally: |MIN| / 1 = MIN, no negate.
  function automatic logic [XLEN-1:0] div_fixup(input logic [5:0]      code,
                                                input logic [XLEN-1:0] dvd,
                                                input logic [XLEN-1:0] dvs,
                                                input logic [XLEN-1:0] q_mag,
                                                input logic [XLEN-1:0] r_mag);
    logic            sgn;
    logic            want_rem;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    sgn      = (code == OP_DIV) || (code == OP_REM);
    want_rem = (code == OP_REM) || (code == OP_REMU);
    q = (sgn && (dvd[XLEN-1] ^ dvs[XLEN-1])) ? -q_mag : q_mag;
    r = (sgn && dvd[XLEN-1]) ? -r_mag : r_mag;
    if (dvs == '0) begin
      q = '1;
      r = dvd;
    end
    return want_rem ? r : q;
  endfunction

  assign in_ready      = (state == S_IDLE) || ((state == S_DONE) && cdb_grant);
  assign accept        = in_flag && in_ready && rdy && !flush;
  assign in_is_mul     = (in_code >= OP_MUL) && (in_code <= OP_MULHU);
  assign in_is_div     = (in_code >= OP_DIV) && (in_code <= OP_REMU);
  assign in_signed_div = (in_code == OP_DIV) || (in_code == OP_REM);

  // ---- single-cycle ALU / branch / jump on the issuing operands ----
  logic signed [XLEN-1:0] sv1;
  logic signed [XLEN-1:0] sv2;
  logic signed [XLEN-1:0] sa;
  logic [XLEN-1:0]        alu_val;
  logic [XLEN-1:0]        alu_rel;
  logic [XLEN-1:0]        pc4;
  logic [XLEN-1:0]        pc_tgt;
  logic [XLEN-1:0]        jalr_tgt;
  logic                   taken;

  always_comb begin
    sv1      = in_v1;
    sv2      = in_v2;
    sa       = in_a;
    pc4      = in_pc + XLEN'(4);
    pc_tgt   = in_pc + in_a;
    jalr_tgt = in_v1 + in_a;
    alu_val  = '0;
    taken    = 1'b0;
    unique case (in_code)
      OP_ADD:   alu_val = in_v1 + in_v2;
      OP_SUB:   alu_val = in_v1 - in_v2;
      OP_SLL:   alu_val = in_v1 << in_v2[4:0];
      OP_SLT:   alu_val = {{(XLEN-1){1'b0}}, sv1 < sv2};
      OP_SLTU:  alu_val = {{(XLEN-1){1'b0}}, in_v1 < in_v2};
      OP_XOR:   alu_val = in_v1 ^ in_v2;
      OP_SRL:   alu_val = in_v1 >> in_v2[4:0];
      OP_SRA:   alu_val = sv1 >>> in_v2[4:0];
      OP_OR:    alu_val = in_v1 | in_v2;
      OP_AND:   alu_val = in_v1 & in_v2;
      OP_ADDI:  alu_val = in_v1 + in_a;
      OP_SLTI:  alu_val = {{(XLEN-1){1'b0}}, sv1 < sa};
      OP_SLTIU: alu_val = {{(XLEN-1){1'b0}}, in_v1 < in_a};
      OP_XORI:  alu_val = in_v1 ^ in_a;
      OP_ORI:   alu_val = in_v1 | in_a;
      OP_ANDI:  alu_val = in_v1 & in_a;
      OP_SLLI:  alu_val = in_v1 << in_a[4:0];
      OP_SRLI:  alu_val = in_v1 >> in_a[4:0];
      OP_SRAI:  alu_val = sv1 >>> in_a[4:0];
      OP_LUI:   alu_val = in_a;
      OP_AUIPC: alu_val = pc_tgt;
      OP_JAL:   alu_val = pc4;
      OP_JALR:  alu_val = pc4;
      OP_BEQ:   taken   = (in_v1 == in_v2);
      OP_BNE:   taken   = (in_v1 != in_v2);
      OP_BLT:   taken   = (sv1 < sv2);
      OP_BGE:   taken   = (sv1 >= sv2);
      OP_BLTU:  taken   = (in_v1 < in_v2);
      OP_BGEU:  taken   = (in_v1 >= in_v2);
      default:  alu_val = '0;
    endcase
    if (in_code == OP_JAL)
      alu_rel = pc_tgt;
    else if (in_code == OP_JALR)
      alu_rel = {jalr_tgt[XLEN-1:1], 1'b0};
    else if (taken)
      alu_rel = pc_tgt;
    else
      alu_rel = pc4;
  end

  // ---- multiplier: operands sign/zero-extended to 2*XLEN, low bits kept ----
  logic [5:0]        mul_code;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_a_sgn;
  logic              mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_code  = MUL_DIRECT ? in_code : code_r;
    mul_a     = MUL_DIRECT ? in_v1   : v1_r;
    mul_b     = MUL_DIRECT ? in_v2   : v2_r;
    mul_a_sgn = (mul_code == OP_MULH) || (mul_code == OP_MULHSU);
    mul_b_sgn = (mul_code == OP_MULH);
    mul_a_ext = {{XLEN{mul_a_sgn & mul_a[XLEN-1]}}, mul_a};
    mul_b_ext = {{XLEN{mul_b_sgn & mul_b[XLEN-1]}}, mul_b};
    prod      = mul_a_ext * mul_b_ext;
    mul_res   = (mul_code == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---- restoring divider step on magnitudes ----
  // rem_r[XLEN-1] set means the shifted partial remainder is >= 2^XLEN and
  // therefore certainly >= the divisor; the true difference always fits.
  logic [XLEN-1:0] rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic [XLEN-1:0] div_res;

  always_comb begin
    rem_sh  = {rem_r[XLEN-2:0], quot_r[XLEN-1]};
    fits    = rem_r[XLEN-1] || (rem_sh >= dvs_r);
    rem_nx  = fits ? (rem_sh - dvs_r) : rem_sh;
    quot_nx = {quot_r[XLEN-2:0], fits};
    div_res = div_fixup(code_r, v1_r, v2_r, quot_nx, rem_nx);
  end

  // ---- operand / divider datapath registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      code_r <= in_code;
      v1_r   <= in_v1;
      v2_r   <= in_v2;
      quot_r <= mag(in_v1, in_signed_div);
      rem_r  <= '0;
      dvs_r  <= mag(in_v2, in_signed_div);
    end else if (rdy && !flush && (state == S_DIV)) begin
      quot_r <= quot_nx;
      rem_r  <= rem_nx;
    end
  end

  // ---- control FSM and registered result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_rob_id <= '0;
      out_val    <= '0;
      out_rel_pc <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (rdy) begin
      if (accept) begin
        out_rob_id <= in_rob_id;
        out_rel_pc <= alu_rel;
        if (in_is_mul && MUL_DIRECT) begin
          out_val   <= mul_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end else if (in_is_mul) begin
          cnt       <= CNT_W'(MUL_CYCLES - 1);
          out_valid <= 1'b0;
          state     <= S_MUL;
        end else if (in_is_div) begin
          cnt       <= CNT_W'(XLEN);
          out_valid <= 1'b0;
          state     <= S_DIV;
        end else begin
          out_val   <= alu_val;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
      end else begin
        unique case (state)
          S_MUL: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              out_val   <= mul_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DIV: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              out_val   <= div_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            if (cdb_grant) begin
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
